// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared constants, state type and helpers for the bus arbiter
package bus_arb_pkg;

  localparam int N_REQ = 32;
  localparam int SEL_W = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Binary index of a one-hot vector; an all-zero vector maps to 0.
  function automatic logic [SEL_W-1:0] onehot_to_index(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority picker: first set bit at or after start
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] start,
  output logic             valid,
  output logic [SEL_W-1:0] index
);

  logic [SEL_W-1:0] cand;

  // Walk start, start+1, ... with natural 5-bit wrap and keep the first hit.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = start + SEL_W'(k);
      if (!valid && mask[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter; forced-release timeout under BUS_ARB_TIMEOUT_EN
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] bus_select,
  output logic             bus_enable,
  output logic             busy,
  output logic [7:0]       owner_cycles
);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             en_nxt;
  logic [7:0]       cyc_nxt;

  logic [SEL_W-1:0] owner;
  logic [SEL_W-1:0] pick_start;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_index;
  logic             timeout;

  assign owner = onehot_to_index(gnt);
  assign busy  = bus_enable;

`ifdef BUS_ARB_TIMEOUT_EN
  assign timeout = (owner_cycles == 8'(MAX_HOLD));
`else
  assign timeout = 1'b0;
`endif

  // In IDLE gnt is zero, so masking by ~gnt only matters when the owner is releasing.
  assign pick_start = (state == IDLE) ? ptr : owner + SEL_W'(1);

  rr_pick u_pick (
    .mask  (req & ~gnt),
    .start (pick_start),
    .valid (pick_valid),
    .index (pick_index)
  );

  // State and registered bus controls; reset releases the bus immediately.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= IDLE;
      ptr          <= '0;
      gnt          <= '0;
      bus_select   <= '0;
      bus_enable   <= 1'b0;
      owner_cycles <= '0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      gnt          <= gnt_nxt;
      bus_select   <= sel_nxt;
      bus_enable   <= en_nxt;
      owner_cycles <= cyc_nxt;
    end
  end

  // Next-state: grant from IDLE, hold while owned, hand off or idle on release.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    sel_nxt   = bus_select;
    en_nxt    = bus_enable;
    cyc_nxt   = owner_cycles;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = OWN;
          gnt_nxt   = N_REQ'(1) << pick_index;
          sel_nxt   = pick_index;
          en_nxt    = 1'b1;
          cyc_nxt   = 8'd1;
        end
      end
      OWN: begin
        if (!req[owner] || timeout) begin
          ptr_nxt = owner + SEL_W'(1);
          if (pick_valid) begin
            gnt_nxt = N_REQ'(1) << pick_index;
            sel_nxt = pick_index;
            cyc_nxt = 8'd1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            en_nxt    = 1'b0;
            cyc_nxt   = '0;
          end
        end else if (owner_cycles != 8'hFF) begin
          cyc_nxt = owner_cycles + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
